// File: rtl/mch_led_pwm_if.sv
// iomem bus bundle between the SoC master and the PWM slave.
interface mch_led_pwm_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );
    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/mch_led_pwm.sv
// Three-channel PWM on iomem with period/duty shadows applied at wrap; fade engine under MCH_LED_PWM_FADE_EN.
// Bus ack one cycle after a selected request (master holds until ready); pwm_out lags cnt by one cycle.
module mch_led_pwm #(
    parameter logic [7:0] BASE_ADDR = 8'h04,
    parameter int         CNT_WIDTH = 16
) (
    input  logic         clk,
    input  logic         resetn,
    mch_led_pwm_if.slave bus,
    output logic [2:0]   pwm_out
);
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    logic [4:0]  ctrl;
    cnt_t        period_sh;
    cnt_t        period_act;
    cnt_t        cnt;
    cnt_t        duty_sh  [3];
    cnt_t        duty_act [3];
    cnt_t        duty_nxt [3];
    logic        wrap_flag;
    logic        en;
    logic        wrap;
    logic        sel;
    logic        we;
    logic [2:0]  off;
    logic [31:0] rd_mux;
    logic [31:0] merged;
    logic        unused_addr;
`ifdef MCH_LED_PWM_FADE_EN
    cnt_t        step_sh;
`endif

    function automatic logic [31:0] ext(input cnt_t v);
        logic [31:0] r;
        r = '0;
        r[CNT_WIDTH-1:0] = v;
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    assign en          = ctrl[0];
    assign wrap        = en && (cnt == period_act);
    assign off         = bus.iomem_addr[4:2];
    assign we          = |bus.iomem_wstrb;
    assign sel         = bus.iomem_valid && !bus.iomem_ready && (bus.iomem_addr[31:24] == BASE_ADDR);
    assign unused_addr = &{1'b0, bus.iomem_addr[23:5], bus.iomem_addr[1:0]};

    always_comb begin
        rd_mux = '0;
        case (off)
            3'd0: rd_mux = {27'd0, ctrl};
            3'd1: rd_mux = ext(period_sh);
            3'd2: rd_mux = ext(duty_sh[0]);
            3'd3: rd_mux = ext(duty_sh[1]);
            3'd4: rd_mux = ext(duty_sh[2]);
            3'd5: begin
                rd_mux     = ext(cnt);
                rd_mux[16] = wrap_flag;
            end
`ifdef MCH_LED_PWM_FADE_EN
            3'd6: rd_mux = ext(step_sh);
`endif
            default: rd_mux = '0;
        endcase
    end

    // Byte-lane merge against the current register contents of the addressed slot.
    assign merged = merge(rd_mux, bus.iomem_wdata, bus.iomem_wstrb);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.iomem_ready <= 1'b0;
            bus.iomem_rdata <= '0;
            ctrl            <= '0;
            period_sh       <= '0;
            wrap_flag       <= 1'b0;
            for (int i = 0; i < 3; i++) duty_sh[i] <= '0;
`ifdef MCH_LED_PWM_FADE_EN
            step_sh         <= '0;
`endif
        end else begin
            bus.iomem_ready <= sel;
            if (sel) bus.iomem_rdata <= rd_mux;
            if (sel && we) begin
                case (off)
`ifdef MCH_LED_PWM_FADE_EN
                    3'd0: ctrl <= merged[4:0];
                    3'd6: step_sh <= cnt_t'(merged);
`else
                    3'd0: ctrl <= {1'b0, merged[3:0]};
`endif
                    3'd1: period_sh  <= cnt_t'(merged);
                    3'd2: duty_sh[0] <= cnt_t'(merged);
                    3'd3: duty_sh[1] <= cnt_t'(merged);
                    3'd4: duty_sh[2] <= cnt_t'(merged);
                    3'd5: if (bus.iomem_wstrb[2] && bus.iomem_wdata[16]) wrap_flag <= 1'b0;
                    default: ;
                endcase
            end
            // A wrap on the same edge as a clear must win.
            if (wrap) wrap_flag <= 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            duty_nxt[i] = duty_sh[i];
`ifdef MCH_LED_PWM_FADE_EN
            if (ctrl[4]) begin
                if (duty_act[i] < duty_sh[i])
                    duty_nxt[i] = ((duty_sh[i] - duty_act[i]) <= step_sh) ? duty_sh[i]
                                                                          : duty_act[i] + step_sh;
                else
                    duty_nxt[i] = ((duty_act[i] - duty_sh[i]) <= step_sh) ? duty_sh[i]
                                                                          : duty_act[i] - step_sh;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt        <= '0;
            period_act <= '0;
            pwm_out    <= '0;
            for (int i = 0; i < 3; i++) duty_act[i] <= '0;
        end else begin
            if (!en) begin
                cnt        <= '0;
                period_act <= period_sh;
                for (int i = 0; i < 3; i++) duty_act[i] <= duty_sh[i];
            end else if (wrap) begin
                cnt        <= '0;
                period_act <= period_sh;
                for (int i = 0; i < 3; i++) duty_act[i] <= duty_nxt[i];
            end else begin
                cnt <= cnt + cnt_t'(1);
            end
            for (int i = 0; i < 3; i++)
                pwm_out[i] <= (en && (cnt < duty_act[i])) ^ ctrl[1+i];
        end
    end
endmodule

// File: tb/tb_mch_led_pwm.sv
// Directed bench for mch_led_pwm: register table, PWM waveform runs, wrap-edge corner cases, isolation, reset.
module tb_mch_led_pwm;
    localparam logic [31:0] B = 32'h0400_0000;
`ifdef MCH_LED_PWM_FADE_EN
    localparam logic [31:0] CTRL_RB = 32'h0000_001E;
    localparam logic [31:0] STEP_RB = 32'h0000_001E;
`else
    localparam logic [31:0] CTRL_RB = 32'h0000_000E;
    localparam logic [31:0] STEP_RB = 32'h0000_0000;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic [2:0] pwm_out;
    int         tests = 0;
    int         fails = 0;

    mch_led_pwm_if bus();
    mch_led_pwm #(.BASE_ADDR(8'h04), .CNT_WIDTH(16)) dut (
        .clk(clk), .resetn(resetn), .bus(bus), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    // Run-length monitor of pwm_out[0]: completed high runs in hq, low runs in lq.
    int hrun = 0, lrun = 0;
    int hq[$];
    int lq[$];
    always @(posedge clk) begin
        #1;
        if (pwm_out[0]) begin
            if (lrun > 0) lq.push_back(lrun);
            lrun = 0;
            hrun++;
        end else begin
            if (hrun > 0) hq.push_back(hrun);
            hrun = 0;
            lrun++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata);
        int waited;
        @(negedge clk);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = addr;
        bus.iomem_wdata = wdata;
        bus.iomem_wstrb = wstrb;
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!bus.iomem_ready && waited < 8);
        rdata = bus.iomem_rdata;
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        check("ack_latency", waited, 1);
        @(posedge clk); #1;
        check("ack_width", {31'd0, bus.iomem_ready}, 0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] d;
        access(addr, wdata, 4'hF, d);
    endtask

    task automatic wait_rise();
        logic prev;
        int   n;
        prev = pwm_out[0];
        for (n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (pwm_out[0] && !prev) break;
            prev = pwm_out[0];
        end
        check("rise_timeout", {31'd0, n >= 60}, 0);
    endtask

    initial begin
        logic [31:0] rd;
        int          ones1, ones2, acks;
        logic [31:0] period_exp;

        bus.iomem_valid = 1'b0;
        bus.iomem_addr  = '0;
        bus.iomem_wdata = '0;
        bus.iomem_wstrb = 4'h0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pwm", {29'd0, pwm_out}, 0);
        check("rst_ready", {31'd0, bus.iomem_ready}, 0);
        check("rst_rdata", bus.iomem_rdata, 0);
        resetn = 1'b1;

        vecs.push_back('{B + 32'h00, 32'h0,         4'h0, 32'h0});
        vecs.push_back('{B + 32'h04, 32'h0,         4'h0, 32'h0});
        vecs.push_back('{B + 32'h08, 32'h0,         4'h0, 32'h0});
        vecs.push_back('{B + 32'h0C, 32'h0,         4'h0, 32'h0});
        vecs.push_back('{B + 32'h10, 32'h0,         4'h0, 32'h0});
        vecs.push_back('{B + 32'h14, 32'h0,         4'h0, 32'h0});
        vecs.push_back('{B + 32'h18, 32'h0,         4'h0, 32'h0});
        vecs.push_back('{B + 32'h1C, 32'h0,         4'h0, 32'h0});
        vecs.push_back('{B + 32'h04, 32'hFFFF_FFFF, 4'hF, 32'h0});
        vecs.push_back('{B + 32'h04, 32'h0,         4'h0, 32'h0000_FFFF});
        vecs.push_back('{B + 32'h04, 32'h0000_0009, 4'h1, 32'h0000_FFFF});
        vecs.push_back('{B + 32'h04, 32'h0,         4'h0, 32'h0000_FF09});
        vecs.push_back('{B + 32'h04, 32'h0,         4'h2, 32'h0000_FF09});
        vecs.push_back('{B + 32'h04, 32'h0,         4'h0, 32'h0000_0009});
        vecs.push_back('{B + 32'h0C, 32'hABCD_1234, 4'h1, 32'h0});
        vecs.push_back('{B + 32'h0C, 32'h0,         4'h0, 32'h0000_0034});
        vecs.push_back('{B + 32'h0C, 32'h0,         4'hF, 32'h0000_0034});
        vecs.push_back('{B + 32'h00, 32'hFFFF_FFFE, 4'hF, 32'h0});
        vecs.push_back('{B + 32'h00, 32'h0,         4'h0, CTRL_RB});
        vecs.push_back('{B + 32'h00, 32'h0,         4'hF, CTRL_RB});
        vecs.push_back('{B + 32'h18, 32'h0000_001E, 4'hF, 32'h0});
        vecs.push_back('{B + 32'h18, 32'h0,         4'h0, STEP_RB});
        vecs.push_back('{B + 32'h18, 32'h0,         4'hF, STEP_RB});
        vecs.push_back('{B + 32'h1C, 32'hFFFF_FFFF, 4'hF, 32'h0});
        vecs.push_back('{B + 32'h1C, 32'h0,         4'h0, 32'h0});
        vecs.push_back('{B + 32'h14, 32'h0,         4'h0, 32'h0});
        for (int i = 0; i < vecs.size(); i++) begin
            access(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd);
            check($sformatf("reg_vec%0d", i), rd, vecs[i].exp);
        end

        // Basic PWM: period 10, duty0 3, duty1 0 (never active), duty2 20 (always active).
        wr(B + 32'h04, 32'd9);
        wr(B + 32'h08, 32'd3);
        wr(B + 32'h0C, 32'd0);
        wr(B + 32'h10, 32'd20);
        hq.delete(); lq.delete();
        wr(B + 32'h00, 32'h1);
        ones1 = 0; ones2 = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #2;
            ones1 += int'(pwm_out[1]);
            ones2 += int'(pwm_out[2]);
        end
        check("basic_high", qget(hq, 1), 3);
        check("basic_low", qget(lq, 1), 7);
        check("duty0_const", ones1, 0);
        check("dutybig_const", ones2, 35);

        wr(B + 32'h00, 32'h3);
        hq.delete(); lq.delete();
        repeat (35) @(posedge clk);
        check("pol_high", qget(hq, 1), 7);
        check("pol_low", qget(lq, 1), 3);
        wr(B + 32'h00, 32'h1);

        // Mid-period duty change keeps the current period.
        wait_rise();
        hq.delete();
        wr(B + 32'h08, 32'd7);
        repeat (25) @(posedge clk);
        check("glitch_cur", qget(hq, 0), 3);
        check("glitch_next", qget(hq, 1), 7);

        // Write committed on the wrap edge misses that wrap.
        wait_rise();
        repeat (8) @(posedge clk);
        hq.delete();
        wr(B + 32'h08, 32'd2);
        repeat (25) @(posedge clk);
        check("wrapedge_cur", qget(hq, 0), 7);
        check("wrapedge_next", qget(hq, 1), 2);

        wait_rise();
        wr(B + 32'h14, 32'h0001_0000);
        access(B + 32'h14, 32'h0, 4'h0, rd);
        check("status_clear", rd, 32'h0000_0003);

        wait_rise();
        repeat (8) @(posedge clk);
        wr(B + 32'h14, 32'h0001_0000);
        access(B + 32'h14, 32'h0, 4'h0, rd);
        check("status_set_wins", rd, 32'h0001_0001);
        period_exp = 32'd9;

`ifdef MCH_LED_PWM_FADE_EN
        wr(B + 32'h00, 32'h0);
        wr(B + 32'h04, 32'd199);
        wr(B + 32'h08, 32'd0);
        wr(B + 32'h18, 32'd30);
        wr(B + 32'h00, 32'h11);
        wr(B + 32'h08, 32'd100);
        hq.delete();
        repeat (1300) @(posedge clk);
        check("fade_w1", qget(hq, 0), 30);
        check("fade_w2", qget(hq, 1), 60);
        check("fade_w3", qget(hq, 2), 90);
        check("fade_w4", qget(hq, 3), 100);
        check("fade_w5", qget(hq, 4), 100);
        period_exp = 32'd199;
`endif

        // Request outside BASE_ADDR: never acknowledged, no state change.
        @(negedge clk);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = 32'h0300_0004;
        bus.iomem_wdata = 32'h55;
        bus.iomem_wstrb = 4'hF;
        acks = 0;
        repeat (6) begin
            @(posedge clk); #1;
            acks += int'(bus.iomem_ready);
        end
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        check("iso_no_ack", acks, 0);
        access(B + 32'h04, 32'h0, 4'h0, rd);
        check("iso_unchanged", rd, period_exp);

        // Reset while a selected request is pending.
        @(negedge clk);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = B + 32'h04;
        bus.iomem_wstrb = 4'h0;
        #2 resetn = 1'b0;
        acks = 0;
        repeat (3) begin
            @(posedge clk); #1;
            acks += int'(bus.iomem_ready);
        end
        check("rstmid_no_ack", acks, 0);
        check("rstmid_pwm", {29'd0, pwm_out}, 0);
        check("rstmid_rdata", bus.iomem_rdata, 0);
        bus.iomem_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        access(B + 32'h04, 32'h0, 4'h0, rd);
        check("rstmid_period", rd, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
